// File: rtl/irq_ack_ctrl_n.sv
// irq_ack_ctrl_n
//   Multi-channel interrupt acknowledge controller. Arbitrates NUM_CH level
//   requests (fixed priority or round-robin), runs a req/ack/done handshake
//   with the winner and aborts a hung handshake after TIMEOUT ACK cycles.
//   Timeouts leave a sticky per-channel error flag.
//
//   Ports
//     clock         in   rising-edge clock
//     RESET_G       in   asynchronous active-high reset
//     irq_req       in   [NUM_CH] level requests, held until released
//     done          in   service complete, only looked at in ACK
//     err_clr       in   one-cycle synchronous clear of err_flag
//     irq_ack       out  [NUM_CH] one-hot acknowledge
//     sel           out  [CH_W] granted channel index
//     status        out  [2] 00 idle, 01 arb/release, 10 serving, 11 timeout
//     enable_count  out  timeout counter running
//     err_pulse     out  one-cycle timeout pulse
//     err_flag      out  [NUM_CH] sticky timeout flags
//
//   state  | meaning
//   S_IDLE | no request being handled
//   S_ARB  | pick winner, load sel, clear counter
//   S_ACK  | acknowledge sel, count cycles until done or timeout
//   S_TOUT | one-cycle abort, flag the channel
//   S_REL  | wait for irq_req[sel] to drop, then record last grant
//
//   All outputs are registered decodes of the current state, so they trail
//   the state register by one clock.
module irq_ack_ctrl_n #(
   parameter int NUM_CH  = 4,
   parameter int CH_W    = 2,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 200,
   parameter bit RR_EN   = 1'b1
) (
   input  logic              clock,
   input  logic              RESET_G,
   input  logic [NUM_CH-1:0] irq_req,
   input  logic              done,
   input  logic              err_clr,
   output logic [NUM_CH-1:0] irq_ack,
   output logic [CH_W-1:0]   sel,
   output logic [1:0]        status,
   output logic              enable_count,
   output logic              err_pulse,
   output logic [NUM_CH-1:0] err_flag
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARB  = 3'd1,
      S_ACK  = 3'd2,
      S_TOUT = 3'd3,
      S_REL  = 3'd4
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [CH_W-1:0]   r_last;
   logic [CH_W-1:0]   w_win;
   logic              w_tout_hit;

   // Scan from farthest to nearest so the nearest set request overwrites.
   // In round-robin mode offset NUM_CH lands on last_grant itself, which
   // therefore has the lowest priority.
   always_comb begin
      w_win = '0;
      if (RR_EN) begin
         for (int i = NUM_CH; i >= 1; i--) begin
            int idx;
            idx = (int'(r_last) + i) % NUM_CH;
            if (irq_req[idx]) w_win = CH_W'(idx);
         end
      end else begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (irq_req[i]) w_win = CH_W'(i);
         end
      end
   end

   assign w_tout_hit = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clock or posedge RESET_G) begin
      if (RESET_G) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_last       <= CH_W'(NUM_CH - 1);
         irq_ack      <= '0;
         sel          <= '0;
         status       <= 2'b00;
         enable_count <= 1'b0;
         err_pulse    <= 1'b0;
         err_flag     <= '0;
      end else begin
         irq_ack      <= '0;
         enable_count <= 1'b0;
         err_pulse    <= 1'b0;
         if (err_clr) err_flag <= '0;

         case (r_state)
            S_IDLE: begin
               status <= 2'b00;
               if (|irq_req) r_state <= S_ARB;
            end
            S_ARB: begin
               status <= 2'b01;
               if (!(|irq_req)) begin
                  r_state <= S_IDLE;
               end else begin
                  sel     <= w_win;
                  r_cnt   <= '0;
                  r_state <= S_ACK;
               end
            end
            S_ACK: begin
               status       <= 2'b10;
               irq_ack      <= NUM_CH'(1) << sel;
               enable_count <= 1'b1;
               if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
               if (done)            r_state <= S_REL;
               else if (w_tout_hit) r_state <= S_TOUT;
            end
            S_TOUT: begin
               status        <= 2'b11;
               err_pulse     <= 1'b1;
               // Placed after the clear so a coincident err_clr loses.
               err_flag[sel] <= 1'b1;
               r_state       <= S_REL;
            end
            S_REL: begin
               status <= 2'b01;
               if (!irq_req[sel]) begin
                  r_last  <= sel;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               status  <= 2'b00;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ack_ctrl_n.sv
// Directed bench for irq_ack_ctrl_n. Three instances share the stimulus:
//   u_rr  round-robin, TIMEOUT=4
//   u_fx  fixed priority, TIMEOUT=4
//   u_nt  round-robin, timeout disabled
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_irq_ack_ctrl_n;

   logic       clock = 1'b0;
   logic       RESET_G = 1'b1;
   logic [3:0] irq_req = '0;
   logic       done = 1'b0;
   logic       err_clr = 1'b0;

   logic [3:0] ack_rr, ack_fx, ack_nt;
   logic [1:0] sel_rr, sel_fx, sel_nt;
   logic [1:0] st_rr, st_fx, st_nt;
   logic       en_rr, en_fx, en_nt;
   logic       ep_rr, ep_fx, ep_nt;
   logic [3:0] ef_rr, ef_fx, ef_nt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   irq_ack_ctrl_n #(.NUM_CH(4), .CH_W(2), .CNT_W(8), .TIMEOUT(4), .RR_EN(1'b1)) u_rr (
      .clock(clock), .RESET_G(RESET_G), .irq_req(irq_req), .done(done), .err_clr(err_clr),
      .irq_ack(ack_rr), .sel(sel_rr), .status(st_rr), .enable_count(en_rr),
      .err_pulse(ep_rr), .err_flag(ef_rr));

   irq_ack_ctrl_n #(.NUM_CH(4), .CH_W(2), .CNT_W(8), .TIMEOUT(4), .RR_EN(1'b0)) u_fx (
      .clock(clock), .RESET_G(RESET_G), .irq_req(irq_req), .done(done), .err_clr(err_clr),
      .irq_ack(ack_fx), .sel(sel_fx), .status(st_fx), .enable_count(en_fx),
      .err_pulse(ep_fx), .err_flag(ef_fx));

   irq_ack_ctrl_n #(.NUM_CH(4), .CH_W(2), .CNT_W(8), .TIMEOUT(0), .RR_EN(1'b1)) u_nt (
      .clock(clock), .RESET_G(RESET_G), .irq_req(irq_req), .done(done), .err_clr(err_clr),
      .irq_ack(ack_nt), .sel(sel_nt), .status(st_nt), .enable_count(en_nt),
      .err_pulse(ep_nt), .err_flag(ef_nt));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      RESET_G = 1'b1;
      irq_req = '0;
      done    = 1'b0;
      err_clr = 1'b0;
      step(2);
      RESET_G = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] exp_rr [4];
      exp_rr[0] = 2'd0; exp_rr[1] = 2'd1; exp_rr[2] = 2'd3; exp_rr[3] = 2'd0;

      // reset values
      #1;
      check("rst_ack", ack_rr, 4'b0000);
      check("rst_sel", sel_rr, 2'd0);
      check("rst_st",  st_rr, 2'b00);
      check("rst_ef",  ef_rr, 4'b0000);
      check("rst_en",  en_rr, 1'b0);
      step(1);
      RESET_G = 1'b0;

      // single request on channel 2, done on the first ACK cycle
      irq_req = 4'b0100;
      step(1);
      check("sgl_st_idle", st_rr, 2'b00);
      step(1);
      check("sgl_sel", sel_rr, 2'd2);
      check("sgl_st_arb", st_rr, 2'b01);
      done = 1'b1;
      step(1);
      check("sgl_ack", ack_rr, 4'b0100);
      check("sgl_st_ack", st_rr, 2'b10);
      check("sgl_en", en_rr, 1'b1);
      done = 1'b0;
      irq_req = 4'b0000;
      step(1);
      check("sgl_st_rel", st_rr, 2'b01);
      check("sgl_ack_off", ack_rr, 4'b0000);
      step(1);
      check("sgl_st_done", st_rr, 2'b00);
      check("sgl_sel_hold", sel_rr, 2'd2);

      // round-robin vs fixed priority with 1011 held
      do_reset();
      irq_req = 4'b1011;
      for (int g = 0; g < 4; g++) begin
         step(2);
         check($sformatf("rr_sel%0d", g), sel_rr, exp_rr[g]);
         check($sformatf("fx_sel%0d", g), sel_fx, 2'd0);
         done = 1'b1;
         step(1);
         done = 1'b0;
         irq_req = 4'b0000;
         step(1);
         irq_req = 4'b1011;
      end
      irq_req = 4'b0000;
      step(3);

      // timeout on channel 1
      do_reset();
      irq_req = 4'b0010;
      step(2);
      check("to_sel", sel_rr, 2'd1);
      for (int c = 0; c < 4; c++) begin
         step(1);
         check($sformatf("to_en%0d", c), en_rr, 1'b1);
         check($sformatf("to_st%0d", c), st_rr, 2'b10);
      end
      step(1);
      check("to_st_tout", st_rr, 2'b11);
      check("to_pulse", ep_rr, 1'b1);
      check("to_ack_off", ack_rr, 4'b0000);
      check("to_en_off", en_rr, 1'b0);
      check("to_flag", ef_rr, 4'b0010);
      step(1);
      check("to_st_rel", st_rr, 2'b01);
      check("to_pulse_off", ep_rr, 1'b0);
      irq_req = 4'b0000;
      step(2);
      check("to_st_idle", st_rr, 2'b00);
      check("to_flag_keep", ef_rr, 4'b0010);

      // done coincides with counter == TIMEOUT-1 on channel 2
      irq_req = 4'b0100;
      step(2);
      check("tie_sel", sel_rr, 2'd2);
      step(3);
      done = 1'b1;
      step(1);
      done = 1'b0;
      step(1);
      check("tie_st", st_rr, 2'b01);
      check("tie_pulse", ep_rr, 1'b0);
      check("tie_flag", ef_rr, 4'b0010);
      irq_req = 4'b0000;
      step(2);

      // err_clr in the same cycle as a new timeout on channel 0
      irq_req = 4'b0001;
      step(2);
      check("clr_sel", sel_rr, 2'd0);
      step(4);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("clr_pulse", ep_rr, 1'b1);
      check("clr_flag", ef_rr, 4'b0001);
      irq_req = 4'b0000;
      step(3);

      // reset in the middle of ACK
      irq_req = 4'b0001;
      step(3);
      check("mid_ack", ack_rr, 4'b0001);
      RESET_G = 1'b1;
      #1;
      check("mid_rst_ack", ack_rr, 4'b0000);
      check("mid_rst_st", st_rr, 2'b00);
      check("mid_rst_ef", ef_rr, 4'b0000);
      check("mid_rst_en", en_rr, 1'b0);
      step(1);
      RESET_G = 1'b0;
      irq_req = 4'b0000;
      step(1);
      check("post_rst_st", st_rr, 2'b00);
      check("post_rst_ack", ack_rr, 4'b0000);
      step(1);
      check("post_rst_st2", st_rr, 2'b00);

      // timeout disabled: counter saturates, no error
      do_reset();
      irq_req = 4'b0001;
      step(2);
      step(300);
      check("nt_st", st_nt, 2'b10);
      check("nt_ack", ack_nt, 4'b0001);
      check("nt_pulse", ep_nt, 1'b0);
      check("nt_flag", ef_nt, 4'b0000);
      check("nt_cnt", u_nt.r_cnt, 8'd255);
      done = 1'b1;
      step(1);
      done = 1'b0;
      irq_req = 4'b0000;
      step(2);
      check("nt_st_idle", st_nt, 2'b00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
